mips_irq_ctl: RTL and testbench

//   Interrupt controller for the device block. Captures rising edges from N

---
 rtl/mips_irq_ctl.sv | 131 +++++++++++++
 tb/tb_mips_irq_ctl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_irq_ctl.sv
// Interrupt controller: rising-edge capture into pending bits, fixed-priority
// selection, and a req/ack/done handshake presenting the handler address.
module mips_irq_ctl #(
  parameter int N_SRC  = 3,
  parameter int ADDR_W = 32,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  src_req,
  input  logic [N_SRC-1:0]  src_en,
  input  logic              global_en,
  input  logic              vec_wr,
  input  logic [SEL_W-1:0]  vec_sel,
  input  logic [ADDR_W-1:0] vec_din,
  input  logic              irq_ack,
  input  logic              irq_done,
  output logic              irq_req_o,
  output logic [ADDR_W-1:0] irq_addr_o,
  output logic [SEL_W-1:0]  irq_id_o,
  output logic [N_SRC-1:0]  pend_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

  state_t            state_reg, state_next;
  logic [N_SRC-1:0]  src_d_reg, pend_reg, pend_next;
  logic [N_SRC-1:0]  rise, clr, eligible;
  logic [ADDR_W-1:0] vec_reg [N_SRC];
  logic              irq_req_reg, irq_req_next;
  logic [ADDR_W-1:0] irq_addr_reg, irq_addr_next;
  logic [SEL_W-1:0]  irq_id_reg, irq_id_next;
  logic [SEL_W-1:0]  win_id;
  logic [ADDR_W-1:0] win_addr;
  logic              held_elig;

  assign rise     = src_req & ~src_d_reg;
  assign eligible = global_en ? (pend_reg & src_en) : '0;
  // A fresh edge in the acknowledge cycle re-arms the source (set wins).
  assign pend_next = (pend_reg & ~clr) | rise;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      assign clr[gi] = (state_reg == REQ) && irq_ack && (irq_id_reg == SEL_W'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vec_reg[gi] <= '0;
        end else if (vec_wr && (vec_sel == SEL_W'(gi))) begin
          vec_reg[gi] <= vec_din;
        end
      end
    end
  endgenerate

  always_comb begin
    win_id    = '0;
    win_addr  = '0;
    held_elig = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_id   = SEL_W'(i);
        win_addr = vec_reg[i];
      end
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (irq_id_reg == SEL_W'(i)) held_elig = eligible[i];
    end
  end

  always_comb begin
    state_next    = state_reg;
    irq_req_next  = irq_req_reg;
    irq_addr_next = irq_addr_reg;
    irq_id_next   = irq_id_reg;
    case (state_reg)
      IDLE: begin
        if (|eligible) begin
          state_next    = REQ;
          irq_req_next  = 1'b1;
          irq_id_next   = win_id;
          irq_addr_next = win_addr;
        end
      end
      REQ: begin
        // Ack takes precedence over done and over an enable drop.
        if (irq_ack) begin
          state_next   = SVC;
          irq_req_next = 1'b0;
        end else if (!held_elig) begin
          state_next   = IDLE;
          irq_req_next = 1'b0;
        end
      end
      SVC: begin
        if (irq_done) state_next = IDLE;
      end
      default: begin
        state_next   = IDLE;
        irq_req_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      src_d_reg    <= '0;
      pend_reg     <= '0;
      irq_req_reg  <= 1'b0;
      irq_addr_reg <= '0;
      irq_id_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      src_d_reg    <= src_req;
      pend_reg     <= pend_next;
      irq_req_reg  <= irq_req_next;
      irq_addr_reg <= irq_addr_next;
      irq_id_reg   <= irq_id_next;
    end
  end

  assign irq_req_o  = irq_req_reg;
  assign irq_addr_o = irq_addr_reg;
  assign irq_id_o   = irq_id_reg;
  assign pend_o     = pend_reg;
  assign busy_o     = (state_reg != IDLE);

endmodule

// File: tb/tb_mips_irq_ctl.sv
// Self-checking bench for mips_irq_ctl: expected requests are queued when
// the source edge is driven and popped when irq_req_o is raised.
module tb_mips_irq_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  src_req, src_en;
  logic        global_en, vec_wr;
  logic [1:0]  vec_sel;
  logic [31:0] vec_din;
  logic        irq_ack, irq_done;
  logic        irq_req_o;
  logic [31:0] irq_addr_o;
  logic [1:0]  irq_id_o;
  logic [2:0]  pend_o;
  logic        busy_o;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  mips_irq_ctl #(.N_SRC(3), .ADDR_W(32), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .src_req(src_req), .src_en(src_en),
    .global_en(global_en), .vec_wr(vec_wr), .vec_sel(vec_sel),
    .vec_din(vec_din), .irq_ack(irq_ack), .irq_done(irq_done),
    .irq_req_o(irq_req_o), .irq_addr_o(irq_addr_o), .irq_id_o(irq_id_o),
    .pend_o(pend_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end else begin
      $display("[TB] ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic pulse_src(input logic [2:0] v);
    src_req = v;
    step();
    src_req = 3'b000;
  endtask

  task automatic write_vec(input logic [1:0] sel, input logic [31:0] d);
    vec_wr = 1'b1; vec_sel = sel; vec_din = d;
    step();
    vec_wr = 1'b0;
  endtask

  // Waits a bounded number of cycles for irq_req_o, then checks against the queue head.
  task automatic wait_req(input string name, input int max_cyc);
    exp_t e;
    int   n;
    n = 0;
    while (irq_req_o !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    tests_run++;
    if (irq_req_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s timeout: irq_req_o=%b after %0d cycles, expected 1", name, irq_req_o, n);
    end else if (exp_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL %s: request id=%0d with empty scoreboard", name, irq_id_o);
    end else begin
      e = exp_q.pop_front();
      if (irq_id_o !== e.id || irq_addr_o !== e.addr) begin
        tests_failed++;
        $display("[TB] FAIL %s: got id=%0d addr=0x%0h, expected id=%0d addr=0x%0h",
                 name, irq_id_o, irq_addr_o, e.id, e.addr);
      end else begin
        $display("[TB] ok   %s: id=%0d addr=0x%0h after %0d cycles", name, irq_id_o, irq_addr_o, n);
      end
    end
  endtask

  task automatic service(input string name);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk({name, " ack req"}, {31'd0, irq_req_o}, 32'd0);
    chk({name, " ack busy"}, {31'd0, busy_o}, 32'd1);
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
    chk({name, " done busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  task automatic test_reset();
    rst = 1'b0; src_req = '0; src_en = 3'b111; global_en = 1'b1;
    vec_wr = 1'b0; vec_sel = '0; vec_din = '0; irq_ack = 1'b0; irq_done = 1'b0;
    step(); step();
    chk("reset irq_req", {31'd0, irq_req_o}, 32'd0);
    chk("reset addr", irq_addr_o, 32'd0);
    chk("reset id", {30'd0, irq_id_o}, 32'd0);
    chk("reset pend", {29'd0, pend_o}, 32'd0);
    chk("reset busy", {31'd0, busy_o}, 32'd0);
    rst = 1'b1;
    step();
    write_vec(2'd0, 32'h100);
    write_vec(2'd1, 32'h200);
    write_vec(2'd2, 32'h300);
    write_vec(2'd3, 32'hDEAD);
  endtask

  task automatic test_basic();
    exp_q.push_back('{2'd1, 32'h200});
    pulse_src(3'b010);
    chk("basic pend after 1clk", {29'd0, pend_o}, 32'h2);
    chk("basic no req after 1clk", {31'd0, irq_req_o}, 32'd0);
    step();
    chk("basic req after 2clk", {31'd0, irq_req_o}, 32'd1);
    wait_req("basic req", 0);
    service("basic");
    chk("basic pend cleared", {29'd0, pend_o}, 32'd0);
  endtask

  task automatic test_priority();
    exp_q.push_back('{2'd0, 32'h100});
    exp_q.push_back('{2'd2, 32'h300});
    pulse_src(3'b101);
    step();
    wait_req("prio first", 0);
    service("prio first");
    chk("prio idle gap", {31'd0, irq_req_o}, 32'd0);
    step();
    wait_req("prio second", 0);
    service("prio second");
  endtask

  task automatic test_no_preempt();
    exp_q.push_back('{2'd2, 32'h300});
    exp_q.push_back('{2'd0, 32'h100});
    exp_q.push_back('{2'd2, 32'h380});
    pulse_src(3'b100);
    step();
    wait_req("nopre held", 0);
    // Higher-priority edge and a vector rewrite arrive mid-handshake.
    src_req = 3'b001; vec_wr = 1'b1; vec_sel = 2'd2; vec_din = 32'h380;
    step();
    src_req = 3'b000; vec_wr = 1'b0;
    chk("nopre addr held", irq_addr_o, 32'h300);
    chk("nopre id held", {30'd0, irq_id_o}, 32'd2);
    chk("nopre pend", {29'd0, pend_o}, 32'h5);
    service("nopre held");
    wait_req("nopre next", 3);
    service("nopre next");
    pulse_src(3'b100);
    wait_req("nopre new vec", 3);
    service("nopre new vec");
  endtask

  task automatic test_masking();
    exp_q.push_back('{2'd1, 32'h200});
    exp_q.push_back('{2'd1, 32'h200});
    src_en = 3'b000;
    pulse_src(3'b010);
    chk("mask pend", {29'd0, pend_o}, 32'h2);
    step(); step();
    chk("mask no req", {31'd0, irq_req_o}, 32'd0);
    chk("mask not busy", {31'd0, busy_o}, 32'd0);
    src_en = 3'b010;
    step();
    chk("mask enable edge", {31'd0, irq_req_o}, 32'd1);
    wait_req("mask enabled", 0);
    global_en = 1'b0;
    step();
    chk("mask gdrop req", {31'd0, irq_req_o}, 32'd0);
    chk("mask gdrop busy", {31'd0, busy_o}, 32'd0);
    chk("mask gdrop pend", {29'd0, pend_o}, 32'h2);
    global_en = 1'b1; src_en = 3'b111;
    wait_req("mask reissue", 3);
    service("mask reissue");
  endtask

  task automatic test_set_wins();
    exp_q.push_back('{2'd1, 32'h200});
    exp_q.push_back('{2'd1, 32'h200});
    pulse_src(3'b010);
    step();
    wait_req("race first", 0);
    irq_ack = 1'b1; src_req = 3'b010;
    step();
    irq_ack = 1'b0; src_req = 3'b000;
    chk("race svc busy", {31'd0, busy_o}, 32'd1);
    chk("race svc req", {31'd0, irq_req_o}, 32'd0);
    chk("race pend kept", {29'd0, pend_o}, 32'h2);
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
    wait_req("race second", 3);
    service("race second");
  endtask

  task automatic test_ignored();
    exp_q.push_back('{2'd0, 32'h100});
    irq_ack = 1'b1; irq_done = 1'b1;
    step();
    irq_ack = 1'b0; irq_done = 1'b0;
    chk("stray idle busy", {31'd0, busy_o}, 32'd0);
    chk("stray idle req", {31'd0, irq_req_o}, 32'd0);
    pulse_src(3'b001);
    wait_req("ackdone req", 3);
    irq_ack = 1'b1; irq_done = 1'b1;
    step();
    irq_ack = 1'b0; irq_done = 1'b0;
    chk("ackdone is ack", {31'd0, busy_o}, 32'd1);
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
    chk("ackdone then done", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic test_async_reset();
    exp_q.push_back('{2'd2, 32'h380});
    exp_q.push_back('{2'd0, 32'h0});
    pulse_src(3'b100);
    wait_req("arst setup", 3);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    pulse_src(3'b011);
    chk("arst svc pend", {29'd0, pend_o}, 32'h3);
    #2 rst = 1'b0;
    #1;
    chk("arst svc req", {31'd0, irq_req_o}, 32'd0);
    chk("arst svc pend lost", {29'd0, pend_o}, 32'd0);
    chk("arst svc busy", {31'd0, busy_o}, 32'd0);
    step();
    rst = 1'b1;
    pulse_src(3'b001);
    wait_req("arst vec cleared", 3);
    #2 rst = 1'b0;
    #1;
    chk("arst req drop", {31'd0, irq_req_o}, 32'd0);
    chk("arst req busy", {31'd0, busy_o}, 32'd0);
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_no_preempt();
    test_masking();
    test_set_wins();
    test_ignored();
    test_async_reset();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard drain: %0d left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
